// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Exhaustive stimulus sequencer and response checker for a 2-to-1 mux stage.
// It walks the packed pattern {sel, in1, in0} through every value from 0 to
// all-ones. Each pattern is held for DWELL_CYCLES cycles so the mux can settle.
// The mux output is then sampled once and compared against sel ? in1 : in0.
// When the sweep ends the block reports a saturating mismatch count, the first
// failing pattern and a pass flag.
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous reset, active-high
//   start_i        one-cycle sweep request, honoured only in IDLE
//   mux_out_i      output of the mux under test
//   sel_o          select driven to the mux (pattern bit 2)
//   in1_o          data input 1 driven to the mux (pattern bit 1)
//   in0_o          data input 0 driven to the mux (pattern bit 0)
//   busy_o         high while a sweep is in progress
//   done_o         one-cycle pulse when the sweep completes
//   pass_o         last completed sweep had zero mismatches
//   err_count_o    mismatch count of the current or last sweep (saturating)
//   first_fail_o   pattern of the first mismatch, valid when err_count_o != 0
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
    parameter int NUM_INPUTS   = 3,
    parameter int DWELL_CYCLES = 10,
    parameter int ERR_W        = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  mux_out_i,
    output logic                  sel_o,
    output logic                  in1_o,
    output logic                  in0_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_W-1:0]      err_count_o,
    output logic [NUM_INPUTS-1:0] first_fail_o
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [NUM_INPUTS-1:0] PAT_LAST   = '1;
    localparam logic [ERR_W-1:0]      ERR_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        ADVANCE,
        FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_INPUTS-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0]      dwellCnt_q, dwellCnt_d;
    logic [ERR_W-1:0]      errCount_q, errCount_d;
    logic [NUM_INPUTS-1:0] firstFail_q, firstFail_d;
    logic                  pass_q, pass_d;
    logic                  expectedOut;
    logic                  driving;

    // Reference behaviour of an ideal 2-to-1 mux for the pattern being held.
    assign expectedOut = pattern_q[2] ? pattern_q[1] : pattern_q[0];

    // State and datapath registers. Reset is synchronous and aborts a sweep
    // outright, so no done pulse can follow it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            dwellCnt_q  <= '0;
            errCount_q  <= '0;
            firstFail_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            dwellCnt_q  <= dwellCnt_d;
            errCount_q  <= errCount_d;
            firstFail_q <= firstFail_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state and datapath update. Results (pass, error count, first
    // failure) are only cleared by an accepted start, so they stay readable
    // in IDLE after a sweep. start is only looked at in IDLE, which makes it
    // ignored both mid-sweep and in the FINISH cycle.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        dwellCnt_d  = dwellCnt_q;
        errCount_d  = errCount_q;
        firstFail_d = firstFail_q;
        pass_d      = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = DRIVE;
                    pattern_d   = '0;
                    dwellCnt_d  = '0;
                    errCount_d  = '0;
                    firstFail_d = '0;
                    pass_d      = 1'b0;
                end
            end
            DRIVE: begin
                dwellCnt_d = dwellCnt_q + 1'b1;
                if (dwellCnt_q == DWELL_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // Only the first mismatch is captured; the count saturates
                // instead of wrapping back to a misleading small value.
                if (mux_out_i != expectedOut) begin
                    if (errCount_q == '0) begin
                        firstFail_d = pattern_q;
                    end
                    if (errCount_q != ERR_MAX) begin
                        errCount_d = errCount_q + 1'b1;
                    end
                end
                state_d = ADVANCE;
            end
            ADVANCE: begin
                if (pattern_q == PAT_LAST) begin
                    state_d = FINISH;
                end else begin
                    pattern_d  = pattern_q + 1'b1;
                    dwellCnt_d = '0;
                    state_d    = DRIVE;
                end
            end
            FINISH: begin
                pass_d  = (errCount_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The pattern is presented throughout DRIVE, SAMPLE and
    // ADVANCE, so the mux inputs change only on entry to the next DRIVE, and
    // are parked at zero in IDLE and FINISH.
    always_comb begin
        driving      = (state_q == DRIVE) || (state_q == SAMPLE) || (state_q == ADVANCE);
        sel_o        = driving & pattern_q[2];
        in1_o        = driving & pattern_q[1];
        in0_o        = driving & pattern_q[0];
        busy_o       = driving;
        done_o       = (state_q == FINISH);
        pass_o       = pass_q;
        err_count_o  = errCount_q;
        first_fail_o = firstFail_q;
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_sequencer
//
// Bench for mux_sel_sequencer with its default parameters (8 patterns, 10-cycle
// dwell, 4-bit error counter). A behavioural mux sits on the sequencer outputs
// and can be ideal, stuck at 0, select-inverted, or ideal with garbage outside
// the sample cycle. Expected per-cycle observations are queued when a sweep is
// launched and popped on each falling edge.
// -----------------------------------------------------------------------------
module tb_mux_sel_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] pat;
        logic [3:0] err;
        logic [2:0] ff;
        logic       pass;
        logic       noise;
    } obs_t;

    localparam int SWEEP_CYCLES = 97;

    logic       clk;
    logic       rst;
    logic       start;
    logic       muxOut;
    logic       sel;
    logic       in1;
    logic       in0;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] errCount;
    logic [2:0] firstFail;

    int   muxMode;
    logic noise;
    obs_t expQ[$];
    int   checkCount;
    int   passCount;

    mux_sel_sequencer #(
        .NUM_INPUTS  (3),
        .DWELL_CYCLES(10),
        .ERR_W       (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .mux_out_i   (muxOut),
        .sel_o       (sel),
        .in1_o       (in1),
        .in0_o       (in0),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .err_count_o (errCount),
        .first_fail_o(firstFail)
    );

    // Behavioural mux under test: 0 ideal, 1 stuck-at-0, 2 inverted select,
    // 3 ideal (corrupted by the noise bit outside the sample cycle).
    function automatic logic muxModel(input int mode, input logic s, input logic i1, input logic i0);
        case (mode)
            1:       return 1'b0;
            2:       return s ? i0 : i1;
            default: return s ? i1 : i0;
        endcase
    endfunction

    assign muxOut = muxModel(muxMode, sel, in1, in0) ^ noise;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Queue the expected observation of every cycle of one sweep plus the
    // first IDLE cycle after it, then raise start. Called on a falling edge.
    task automatic applyStimulus(input int mode);
        int         errs;
        logic [2:0] ff;
        obs_t       e;
        errs = 0;
        ff   = 3'd0;
        muxMode = mode;
        for (int k = 1; k <= SWEEP_CYCLES + 1; k++) begin
            e = '0;
            if (k <= SWEEP_CYCLES - 1) begin
                logic [2:0] p;
                int         ph;
                logic       want;
                logic       got;
                p  = 3'((k - 1) / 12);
                ph = (k - 1) % 12;
                // The sample edge closes phase 10, so its effect shows from phase 11.
                if (ph == 11) begin
                    want = p[2] ? p[1] : p[0];
                    got  = muxModel(mode, p[2], p[1], p[0]);
                    if (want != got) begin
                        if (errs == 0) ff = p;
                        if (errs < 15) errs++;
                    end
                end
                e.busy  = 1'b1;
                e.pat   = p;
                e.noise = (mode == 3) && (ph != 10);
            end else if (k == SWEEP_CYCLES) begin
                e.done = 1'b1;
            end else begin
                e.pass = (errs == 0);
            end
            e.err = 4'(errs);
            e.ff  = ff;
            expQ.push_back(e);
        end
        start = 1'b1;
    endtask

    // Pop and compare one entry per falling edge. Optionally raises start
    // again at cycle extraStartAt, or asserts reset at cycle resetAt and
    // returns early with the queue flushed.
    task automatic checkOutput(input int extraStartAt, input int resetAt);
        obs_t e;
        for (int k = 1; k <= SWEEP_CYCLES + 1; k++) begin
            @(negedge clk);
            start = (k == extraStartAt);
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL scoreboard cycle %0d: got empty queue required entry", k);
                return;
            end
            e = expQ.pop_front();
            checkCount++;
            if ({sel, in1, in0} !== e.pat)
                $display("[TB] FAIL pattern cycle %0d: got %0d required %0d", k, {sel, in1, in0}, e.pat);
            else passCount++;
            checkCount++;
            if (busy !== e.busy)
                $display("[TB] FAIL busy cycle %0d: got %0b required %0b", k, busy, e.busy);
            else passCount++;
            checkCount++;
            if (done !== e.done)
                $display("[TB] FAIL done cycle %0d: got %0b required %0b", k, done, e.done);
            else passCount++;
            checkCount++;
            if (errCount !== e.err)
                $display("[TB] FAIL err_count cycle %0d: got %0d required %0d", k, errCount, e.err);
            else passCount++;
            checkCount++;
            if (firstFail !== e.ff)
                $display("[TB] FAIL first_fail cycle %0d: got %0d required %0d", k, firstFail, e.ff);
            else passCount++;
            checkCount++;
            if (pass !== e.pass)
                $display("[TB] FAIL pass cycle %0d: got %0b required %0b", k, pass, e.pass);
            else passCount++;
            // Mux noise for the cycle starting now.
            noise = e.noise;
            if (k == resetAt) begin
                rst   = 1'b1;
                noise = 1'b0;
                expQ.delete();
                return;
            end
        end
        noise = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        noise = 1'b0;
        muxMode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkCount++;
            if ({sel, in1, in0, busy, done, pass, errCount, firstFail} !== 13'd0)
                $display("[TB] FAIL reset_idle cycle %0d: got %0h required 0", k,
                         {sel, in1, in0, busy, done, pass, errCount, firstFail});
            else passCount++;
        end
    endtask

    task automatic test_clean_sweep();
        $display("[TB] clean sweep, ideal mux");
        applyStimulus(0);
        checkOutput(0, 0);
    endtask

    task automatic test_stuck_at_zero();
        $display("[TB] stuck-at-0 mux");
        applyStimulus(1);
        checkOutput(0, 0);
        checkCount++;
        if (errCount !== 4'd4 || firstFail !== 3'b001)
            $display("[TB] FAIL stuck0_summary: got err=%0d ff=%0d required err=4 ff=1", errCount, firstFail);
        else passCount++;
    endtask

    task automatic test_inverted_select();
        $display("[TB] inverted-select mux");
        applyStimulus(2);
        checkOutput(0, 0);
        checkCount++;
        if (errCount !== 4'd4 || firstFail !== 3'b001)
            $display("[TB] FAIL invsel_summary: got err=%0d ff=%0d required err=4 ff=1", errCount, firstFail);
        else passCount++;
    endtask

    task automatic test_settle_noise();
        $display("[TB] mux wrong everywhere except the sample cycle");
        applyStimulus(3);
        checkOutput(0, 0);
    endtask

    task automatic test_start_while_busy();
        $display("[TB] start re-asserted at cycle 40");
        applyStimulus(0);
        checkOutput(40, 0);
    endtask

    task automatic test_reset_mid_sweep();
        $display("[TB] reset at cycle 50");
        applyStimulus(2);
        checkOutput(0, 50);
        @(negedge clk);
        checkCount++;
        if ({sel, in1, in0, busy, done, pass, errCount, firstFail} !== 13'd0)
            $display("[TB] FAIL reset_abort: got %0h required 0",
                     {sel, in1, in0, busy, done, pass, errCount, firstFail});
        else passCount++;
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checkCount++;
            if (busy !== 1'b0 || done !== 1'b0)
                $display("[TB] FAIL post_reset_quiet cycle %0d: got busy=%0b done=%0b required 0 0", k, busy, done);
            else passCount++;
        end
        applyStimulus(0);
        checkOutput(0, 0);
    endtask

    // start held during FINISH must be dropped; start on the following IDLE
    // cycle launches the next sweep immediately.
    task automatic test_back_to_back();
        $display("[TB] start in FINISH, then back-to-back start in IDLE");
        applyStimulus(1);
        checkOutput(SWEEP_CYCLES, 0);
        applyStimulus(0);
        checkOutput(0, 0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        test_reset();
        test_clean_sweep();
        test_stuck_at_zero();
        test_inverted_select();
        test_settle_noise();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
